// File: rtl/const_div_serial.sv
// ---------------------------------------------------------------------------
// const_div_serial
//   Sequential unsigned divide-by-constant. Each RUN cycle consumes
//   RADIX_BITS dividend bits, MSB first:
//     t = rem*2^RADIX_BITS + chunk;  qd = t / DIVISOR;  rem' = t % DIVISOR
//   Quotient digits are shifted into the LSBs of the same register that
//   holds the dividend. After N = WIDTH/RADIX_BITS steps, that register
//   holds the quotient and rem holds the remainder.
//
// Ports
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous active-high reset
//   in_valid       in   1      dividend offered
//   in_ready       out  1      unit idle and able to accept a dividend
//   in_dividend    in   WIDTH  dividend, captured on in_valid & in_ready
//   out_valid      out  1      result available (DONE state)
//   out_ready      in   1      consumer takes the result
//   out_quotient   out  WIDTH  floor(dividend / DIVISOR)
//   out_remainder  out  REM_W  dividend mod DIVISOR
//   busy           out  1      operation in progress or result pending
// ---------------------------------------------------------------------------
module const_div_serial #(
   parameter int unsigned  WIDTH      = 32,
   parameter int unsigned  DIVISOR    = 23,
   parameter int unsigned  RADIX_BITS = 1,
   localparam int unsigned REM_W      = $clog2(DIVISOR)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_dividend,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_quotient,
   output logic [REM_W-1:0]   out_remainder,
   output logic               busy
);

   // Guarded divisor keeps the derived constants legal, so the parameter
   // check below reports the real problem instead of a divide-by-zero.
   localparam int unsigned RB_SAFE = (RADIX_BITS == 0) ? 1 : RADIX_BITS;
   localparam int unsigned N       = WIDTH / RB_SAFE;
   localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned T_W     = REM_W + RADIX_BITS;

   if (DIVISOR < 2 || RADIX_BITS < 1 || RADIX_BITS > 4 ||
       (WIDTH % RB_SAFE) != 0) begin : g_param_check
      $error("const_div_serial: illegal DIVISOR/WIDTH/RADIX_BITS combination");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [WIDTH-1:0]      r_shreg;
   logic [REM_W-1:0]      r_rem;
   logic [CNT_W-1:0]      r_count;

   logic [RADIX_BITS-1:0] w_chunk;
   logic [RADIX_BITS-1:0] w_qd;
   logic [T_W-1:0]        w_t;
   logic [REM_W-1:0]      w_rem_nxt;
   logic                  w_accept;
   logic                  w_step;
   logic                  w_last;

   // One digit-recurrence step. rem < DIVISOR bounds t below
   // DIVISOR*2^RADIX_BITS, so qd always fits in RADIX_BITS bits and the
   // truncating casts lose nothing.
   assign w_chunk   = r_shreg[WIDTH-1 -: RADIX_BITS];
   assign w_t       = {r_rem, w_chunk};
   assign w_qd      = RADIX_BITS'(w_t / T_W'(DIVISOR));
   assign w_rem_nxt = REM_W'(w_t % T_W'(DIVISOR));
   assign w_last    = (r_count == CNT_W'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '0;
         r_rem   <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_shreg <= in_dividend;
         r_rem   <= '0;
         r_count <= '0;
      end else if (w_step) begin
         // Dividend bits leave at the top while quotient digits enter at
         // the bottom; after N steps only quotient bits remain.
         r_shreg <= (r_shreg << RADIX_BITS) | WIDTH'(w_qd);
         r_rem   <= w_rem_nxt;
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign in_ready      = (r_state == S_IDLE);
   assign out_valid     = (r_state == S_DONE);
   assign busy          = (r_state != S_IDLE);
   assign out_quotient  = r_shreg;
   assign out_remainder = r_rem;

endmodule

// File: tb/tb_const_div_serial.sv
// ---------------------------------------------------------------------------
// tb_const_div_serial
//   Two units in parallel: unit 0 with RADIX_BITS=1 (N=32) and unit 1 with
//   RADIX_BITS=4 (N=8). Expected results come from plain / and % on the
//   dividend; latency is measured in edges from the accept edge.
// ---------------------------------------------------------------------------
module tb_const_div_serial;

   localparam int unsigned DIV = 23;

   typedef struct {
      logic [31:0] d;
      logic [31:0] q;
      logic [4:0]  r;
   } vec_t;

   logic            clk = 1'b0;
   logic [1:0]      rst;
   logic [1:0]      in_valid;
   logic [1:0]      in_ready;
   logic [1:0][31:0] in_div;
   logic [1:0]      out_valid;
   logic [1:0]      out_ready;
   logic [1:0][31:0] out_q;
   logic [1:0][4:0] out_r;
   logic [1:0]      busy;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   const_div_serial #(.WIDTH(32), .DIVISOR(DIV), .RADIX_BITS(1)) u_r1 (
      .clk(clk), .rst(rst[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_dividend(in_div[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_quotient(out_q[0]), .out_remainder(out_r[0]), .busy(busy[0])
   );

   const_div_serial #(.WIDTH(32), .DIVISOR(DIV), .RADIX_BITS(4)) u_r4 (
      .clk(clk), .rst(rst[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_dividend(in_div[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_quotient(out_q[1]), .out_remainder(out_r[1]), .busy(busy[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nsteps(input int u);
      return (u == 0) ? 32 : 8;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] m;
      case ($urandom_range(0, 3))
         0: return 32'($urandom);
         1: return 32'($urandom_range(0, 100));
         2: begin
            m = 32'($urandom) / DIV;
            return m * DIV + 32'($urandom_range(0, 1));
         end
         default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
      endcase
   endfunction

   // Full transaction: offer d, wait for the result, then release it.
   // rnd=1 randomizes out_ready (including backpressure in DONE).
   task automatic run_div(input int u, input logic [31:0] d, input bit rnd,
                          output logic [31:0] q, output logic [4:0] r,
                          output int lat);
      bit ro;
      int w;
      q   = '0;
      r   = '0;
      lat = 0;
      w   = 0;
      while (!in_ready[u] && w < 100) begin
         tick();
         w++;
      end
      if (!in_ready[u]) begin
         chk("accept_timeout", 1, 0);
         return;
      end
      in_valid[u] = 1'b1;
      in_div[u]   = d;
      tick();
      in_valid[u] = 1'b0;
      in_div[u]   = 32'($urandom);
      while (!out_valid[u] && lat < 200) begin
         chk("run_in_ready", in_ready[u], 0);
         chk("run_busy", busy[u], 1);
         out_ready[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         lat++;
      end
      if (!out_valid[u]) begin
         chk("result_timeout", 1, 0);
         return;
      end
      q = out_q[u];
      r = out_r[u];
      for (int c = 0; c < 64; c++) begin
         ro = rnd ? (($urandom_range(0, 2) == 0) || c >= 16) : 1'b1;
         chk("done_valid", out_valid[u], 1);
         chk("done_in_ready", in_ready[u], 0);
         chk("done_q_stable", out_q[u], q);
         chk("done_r_stable", out_r[u], r);
         out_ready[u] = ro;
         tick();
         if (ro) break;
      end
      chk("drop_valid", out_valid[u], 0);
      chk("back_in_ready", in_ready[u], 1);
      out_ready[u] = 1'b0;
   endtask

   task automatic table_test(input int u);
      vec_t tv[8];
      logic [31:0] q;
      logic [4:0]  r;
      int lat;
      tv[0] = '{32'd100,        32'd4,         5'd8};
      tv[1] = '{32'hFFFF_FFFF,  32'd186737708, 5'd11};
      tv[2] = '{32'd0,          32'd0,         5'd0};
      tv[3] = '{32'd22,         32'd0,         5'd22};
      tv[4] = '{32'd23,         32'd1,         5'd0};
      tv[5] = '{32'd46,         32'd2,         5'd0};
      tv[6] = '{32'h8000_0000,  32'd93368854,  5'd6};
      tv[7] = '{32'd1000,       32'd43,        5'd11};
      for (int i = 0; i < 8; i++) begin
         run_div(u, tv[i].d, 1'b0, q, r, lat);
         chk($sformatf("u%0d_vec%0d_q", u, i), q, tv[i].q);
         chk($sformatf("u%0d_vec%0d_r", u, i), r, tv[i].r);
         chk($sformatf("u%0d_vec%0d_latency", u, i), lat + 1, nsteps(u) + 1);
      end
   endtask

   task automatic random_test(input int u, input int count);
      logic [31:0] d;
      logic [31:0] q;
      logic [4:0]  r;
      int lat;
      for (int i = 0; i < count; i++) begin
         d = pick();
         run_div(u, d, 1'b1, q, r, lat);
         chk($sformatf("u%0d_rand_q", u), q, d / DIV);
         chk($sformatf("u%0d_rand_r", u), r, d % DIV);
         chk($sformatf("u%0d_rand_latency", u), lat + 1, nsteps(u) + 1);
      end
   endtask

   task automatic backpressure_test();
      logic [31:0] d;
      int w;
      d = 32'h1234_5678;
      w = 0;
      while (!in_ready[0] && w < 100) begin tick(); w++; end
      in_valid[0] = 1'b1;
      in_div[0]   = d;
      tick();
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      w = 0;
      while (!out_valid[0] && w < 200) begin tick(); w++; end
      chk("bp_reached_done", out_valid[0], 1);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", out_valid[0], 1);
         chk("bp_in_ready", in_ready[0], 0);
         chk("bp_busy", busy[0], 1);
         chk("bp_q", out_q[0], d / DIV);
         chk("bp_r", out_r[0], d % DIV);
         in_valid[0] = 1'b1;
         in_div[0]   = 32'hDEAD_BEEF;
         tick();
      end
      in_valid[0]  = 1'b0;
      chk("bp_q_after_hold", out_q[0], d / DIV);
      chk("bp_r_after_hold", out_r[0], d % DIV);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk("bp_drop_valid", out_valid[0], 0);
      chk("bp_in_ready_back", in_ready[0], 1);
      tick();
      chk("bp_no_capture", busy[0], 0);
   endtask

   task automatic reset_mid_run_test();
      logic [31:0] q;
      logic [4:0]  r;
      int lat;
      bit seen;
      int w;
      w = 0;
      while (!in_ready[0] && w < 100) begin tick(); w++; end
      in_valid[0] = 1'b1;
      in_div[0]   = 32'd5000;
      tick();
      in_valid[0] = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      chk("mid_busy_before_rst", busy[0], 1);
      rst[0] = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid[0], 0);
      chk("mid_rst_in_ready", in_ready[0], 1);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_q", out_q[0], 0);
      chk("mid_rst_r", out_r[0], 0);
      tick();
      rst[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid[0]) seen = 1'b1;
         tick();
      end
      chk("mid_rst_no_pulse", seen, 0);
      chk("mid_rst_idle", in_ready[0], 1);
      run_div(0, 32'd1000, 1'b0, q, r, lat);
      chk("mid_rst_next_q", q, 43);
      chk("mid_rst_next_r", r, 11);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = '1;
      in_valid  = '0;
      out_ready = '0;
      in_div    = '0;
      #2;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d_rst_in_ready", u), in_ready[u], 1);
         chk($sformatf("u%0d_rst_out_valid", u), out_valid[u], 0);
         chk($sformatf("u%0d_rst_busy", u), busy[u], 0);
         chk($sformatf("u%0d_rst_q", u), out_q[u], 0);
         chk($sformatf("u%0d_rst_r", u), out_r[u], 0);
      end
      tick();
      tick();
      rst = '0;
      tick();
      fork
         begin
            table_test(0);
            backpressure_test();
            reset_mid_run_test();
            random_test(0, 1200);
         end
         begin
            table_test(1);
            random_test(1, 3000);
         end
      join
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
